// File: rtl/img_pkg.sv
// Shared definitions for the 3x3 binary dilation pipeline.
//   COL_DFLT / ROW_DFLT : default frame geometry
//   CNT_W               : width of the linear position counters
//   PIX_FG / PIX_BG     : output pixel codes
//   state_e             : controller state encoding
package img_pkg;

  localparam int COL_DFLT = 640;
  localparam int ROW_DFLT = 480;
  localparam int CNT_W    = 19;

  localparam logic [7:0] PIX_FG = 8'hFF;
  localparam logic [7:0] PIX_BG = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/line_buffer_1b.sv
// DEPTH-deep 1-bit delay line built as a circular RAM. The same address is
// read and then overwritten on every enabled cycle, so q is the bit that
// was written DEPTH enables ago. Contents are not reset.
//   clk : clock          rst : async active-high reset (pointer only)
//   en  : advance        d   : bit in       q : bit delayed by DEPTH
module line_buffer_1b
  import img_pkg::*;
#(
  parameter int DEPTH = COL_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          mem_q [DEPTH];
  logic [AW-1:0] ptr_q;

  assign q = mem_q[ptr_q];

  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/image_dilation_3x3.sv
// Streaming 3x3 binary dilation, one pixel per clock in raster order.
// Outputs lag accepted inputs by COL+1 positions; the tail of the frame is
// flushed with background as the virtual row below the image.
//   clk, rst          : clock, async active-high reset
//   data_in, in_valid : input pixel and qualifier, accepted with in_ready
//   in_ready          : pixel can be accepted this cycle
//   data_out, w_en    : dilated pixel (FF/00) and its one-cycle strobe
//   frame_done        : pulses with the last output pixel of a frame
//
// state | meaning
// IDLE  | waiting for the first pixel of a frame
// FILL  | priming line buffers, first COL+1 pixels, no output
// RUN   | each accepted pixel yields one output next cycle
// FLUSH | input closed, emit remaining COL+1 outputs
module image_dilation_3x3
  import img_pkg::*;
#(
  parameter int COL    = COL_DFLT,
  parameter int ROW    = ROW_DFLT,
  parameter int THRESH = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       w_en,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(ROW * COL - 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW - 1);

  state_e           state_q;
  logic [CNT_W-1:0] in_cnt_q, out_cnt_q, out_col_q, out_row_q;
  logic             in_ready_q, w_en_q, frame_done_q;
  logic [7:0]       data_out_q;
  // Window columns c-1 and c; bit0 = row r-1, bit1 = row r, bit2 = row r+1.
  logic [2:0]       win_l_q, win_m_q;

  logic       accept, step, emit, last_out, fg_in, lb0_rd, lb1_rd, dil_d;
  logic [2:0] col_new, row_mask, win_d;

  assign accept   = in_valid && in_ready_q && (state_q != FLUSH);
  assign step     = accept || (state_q == FLUSH);
  assign emit     = (accept && (state_q == RUN)) || (state_q == FLUSH);
  assign last_out = (out_cnt_q == LAST_PIX);
  assign fg_in    = (state_q != FLUSH) && (data_in >= 8'(THRESH));

  line_buffer_1b #(.DEPTH(COL)) u_lb0 (
    .clk(clk), .rst(rst), .en(step), .d(fg_in), .q(lb0_rd)
  );
  line_buffer_1b #(.DEPTH(COL)) u_lb1 (
    .clk(clk), .rst(rst), .en(step), .d(lb0_rd), .q(lb1_rd)
  );

  // Newest column sits at col c+1 of the window. At col COL-1 it actually
  // holds column 0 of later rows, so it must be masked, as must the left
  // column at col 0. Top/bottom rows are masked at the frame edges, which
  // also hides stale line-buffer content from a previous frame.
  assign col_new  = {fg_in, lb0_rd, lb1_rd};
  assign row_mask = {out_row_q != ROW_LAST, 1'b1, out_row_q != '0};
  assign win_d    = ((win_l_q & {3{out_col_q != '0}})
                   | win_m_q
                   | (col_new & {3{out_col_q != COL_LAST}})) & row_mask;
  assign dil_d    = |win_d;

  assign in_ready   = in_ready_q;
  assign data_out   = data_out_q;
  assign w_en       = w_en_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      in_ready_q   <= 1'b0;
      w_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      data_out_q   <= PIX_BG;
      win_l_q      <= '0;
      win_m_q      <= '0;
    end else begin
      w_en_q       <= emit;
      frame_done_q <= emit && last_out;

      if (emit) begin
        data_out_q <= dil_d ? PIX_FG : PIX_BG;
        if (last_out) begin
          out_cnt_q <= '0;
          out_col_q <= '0;
          out_row_q <= '0;
        end else begin
          out_cnt_q <= out_cnt_q + 1'b1;
          if (out_col_q == COL_LAST) begin
            out_col_q <= '0;
            out_row_q <= out_row_q + 1'b1;
          end else begin
            out_col_q <= out_col_q + 1'b1;
          end
        end
      end

      if (step) begin
        win_m_q <= col_new;
        win_l_q <= win_m_q;
      end

      case (state_q)
        // in_ready rises one cycle after entering IDLE, so nothing is taken
        // in the frame_done cycle.
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_cnt_q <= CNT_W'(1);
            state_q  <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == CNT_W'(COL)) state_q <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (in_cnt_q == LAST_PIX) begin
              in_cnt_q   <= '0;
              in_ready_q <= 1'b0;
              state_q    <= FLUSH;
            end else begin
              in_cnt_q <= in_cnt_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (last_out) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_dilation_3x3.sv
module tb_image_dilation_3x3;

  localparam int COL    = 8;
  localparam int ROW    = 6;
  localparam int THRESH = 128;
  localparam int NPIX   = COL * ROW;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       w_en;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int out_idx  = 0;
  bit aborting = 1'b0;

  logic [7:0] img [NPIX];
  logic [8:0] sb_q [$];

  image_dilation_3x3 #(.COL(COL), .ROW(ROW), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .w_en(w_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at output %0d", name, out_idx);
  endtask

  // Reference: OR of foreground over the in-image 3x3 neighbourhood.
  task automatic push_expected();
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        bit hit = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (rr >= 0 && rr < ROW && cc >= 0 && cc < COL)
              if (img[rr*COL+cc] >= 8'(THRESH)) hit = 1'b1;
          end
        end
        sb_q.push_back({(r == ROW-1) && (c == COL-1), hit ? 8'hFF : 8'h00});
      end
    end
  endtask

  // Monitor: every strobe is matched against the scoreboard.
  initial begin
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && !aborting) begin
        if (w_en) begin
          if (sb_q.size() == 0) begin
            fail("unexpected_wen");
          end else begin
            exp = sb_q.pop_front();
            check($sformatf("pixel_%0d", out_idx), 32'({frame_done, data_out}), 32'(exp));
          end
          out_idx = (frame_done) ? 0 : out_idx + 1;
        end else if (frame_done) begin
          fail("frame_done_without_wen");
        end
      end
    end
  end

  task automatic clear_img();
    for (int k = 0; k < NPIX; k++) img[k] = 8'h00;
  endtask

  task automatic rand_img();
    for (int k = 0; k < NPIX; k++) begin
      case ($urandom_range(0, 19))
        0:       img[k] = 8'd128;
        1:       img[k] = 8'd127;
        2:       img[k] = 8'($urandom_range(129, 255));
        default: img[k] = 8'($urandom_range(0, 126));
      endcase
    end
  endtask

  task automatic send_frame(input bit gaps, input int abort_at);
    int timing_errs = 0;
    int guard;
    bit acc;
    bit exp_wen = 1'b0;
    aborting = (abort_at >= 0);
    if (!aborting) push_expected();
    for (int k = 0; k < NPIX; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        if (w_en !== exp_wen) timing_errs++;
        if (k > 0 && in_ready !== 1'b1) timing_errs++;
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        data_in  = img[k];
        acc      = in_valid && in_ready;
        exp_wen  = acc && (k >= COL + 1);
        if (!acc) begin
          guard++;
          if (guard > 64) begin
            $display("FAIL in_ready_timeout: pixel %0d never accepted", k);
            $fatal(1, "in_ready timeout");
          end
        end
      end while (!acc);
      if (k == abort_at) begin
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_outputs", 32'({in_ready, w_en, frame_done, data_out}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        out_idx  = 0;
        aborting = 1'b0;
        return;
      end
    end
    // Last RUN output, then COL+1 flush outputs; input closed throughout.
    for (int i = 0; i < COL + 2; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (w_en !== 1'b1) timing_errs++;
      if (in_ready !== 1'b0) timing_errs++;
      if (frame_done !== (i == COL + 1)) timing_errs++;
    end
    #1;
    check("handshake_timing", 32'(timing_errs), 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({in_ready, w_en, frame_done, data_out}), 32'd0);
    rst = 1'b0;

    clear_img();                                  send_frame(1'b0, -1);
    clear_img(); img[2*COL+3] = 8'hC8;            send_frame(1'b0, -1);
    clear_img(); img[0*COL+7] = 8'hFF;            send_frame(1'b0, -1);
    clear_img(); img[3*COL+3] = 8'h7F;            send_frame(1'b0, -1);
    clear_img(); img[3*COL+3] = 8'h80;            send_frame(1'b0, -1);
    clear_img(); img[2*COL+3] = 8'hC8;            send_frame(1'b1, -1);

    for (int k = 0; k < NPIX; k++) img[k] = 8'hFF;
    send_frame(1'b0, 20);
    clear_img(); img[0] = 8'hFF;                  send_frame(1'b0, -1);

    repeat (5) begin
      rand_img();
      send_frame(1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
